// File: rtl/cpu_run_ctrl.sv
// Run/clock controller for the mu0 core: derives a one-cycle cpu_tick enable from the
// selected clock mode and tracks IDLE/RUN/HALT with the reason the core last stopped.
module cpu_run_ctrl #(
    parameter int CLK_DIV = 6318000,
    parameter int PC_W    = 16,
    parameter int STEP_W  = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic              start_tgl,
    input  logic              done,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    output logic              cpu_tick,
    output logic              slow_clk,
    output logic              running,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] M_FAST   = 3'd1;
    localparam logic [2:0] M_SLOW   = 3'd2;
    localparam logic [2:0] M_MAN_LO = 3'd3;
    localparam logic [2:0] M_MAN_HI = 3'd4;
    localparam logic [2:0] M_STEP   = 3'd5;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_DONE = 2'd1;
    localparam logic [1:0] C_BP   = 2'd2;
    localparam logic [1:0] C_STEP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [2:0]         mode_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               slow_clk_q, slow_clk_d, slow_src_s;
    logic [STEP_W-1:0]  remaining_q, remaining_d;
    logic               bp_armed_q, bp_armed_d;
    logic               left_step_q, left_step_d;
    logic               cpu_tick_q, cpu_tick_d;
    logic [1:0]         halt_cause_q, halt_cause_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               running_q;

    logic               mode_chg_s, step_mode_s, raw_edge_s;
    logic               start_entry_s, step_entry_s, halt_s;
    logic [1:0]         cause_s;

    // Raw-edge source: per-mode virtual clock level and divider.
    always_comb begin
        mode_chg_s  = (mode != mode_q);
        step_mode_s = (mode == M_STEP);
        div_d       = '0;
        slow_src_s  = 1'b0;
        raw_edge_s  = 1'b0;
        if (step_mode_s) begin
            raw_edge_s = (state_q == ST_RUN) && (remaining_q != '0);
        end else if (mode_chg_s) begin
            slow_src_s = (mode == M_MAN_HI);
            raw_edge_s = slow_src_s & ~slow_clk_q;
        end else begin
            case (mode)
                M_FAST: begin
                    slow_src_s = ~slow_clk_q;
                    raw_edge_s = ~slow_clk_q;
                end
                M_SLOW: begin
                    if (div_q == DIV_LAST) begin
                        div_d      = '0;
                        slow_src_s = ~slow_clk_q;
                        raw_edge_s = ~slow_clk_q;
                    end else begin
                        div_d      = div_q + DIV_W'(1);
                        slow_src_s = slow_clk_q;
                    end
                end
                M_MAN_LO: slow_src_s = 1'b0;
                M_MAN_HI: begin
                    slow_src_s = 1'b1;
                    raw_edge_s = ~slow_clk_q;
                end
                default: slow_src_s = 1'b0;
            endcase
        end
    end

    // Run-state next values: entry, halt priority, tick issue and step budget.
    always_comb begin
        start_entry_s = (state_q != ST_RUN) && !step_mode_s && (start_tgl != start_q);
        step_entry_s  = (state_q != ST_RUN) && step_mode_s && step_req && (step_count != '0);

        halt_s  = 1'b0;
        cause_s = C_NONE;
        if (state_q == ST_RUN) begin
            if (done) begin
                halt_s  = 1'b1;
                cause_s = C_DONE;
            end else if (bp_en && bp_armed_q && (pc == bp_addr)) begin
                halt_s  = 1'b1;
                cause_s = C_BP;
            end else if ((step_mode_s || left_step_q) && (remaining_q == '0)) begin
                halt_s  = 1'b1;
                cause_s = C_STEP;
            end else begin
                halt_s  = 1'b0;
            end
        end else begin
            halt_s = 1'b0;
        end

        cpu_tick_d = (state_q == ST_RUN) && raw_edge_s && !halt_s;
        slow_clk_d = step_mode_s ? cpu_tick_d : slow_src_s;

        // A burst cut short by leaving STEP must still report an exhausted budget.
        left_step_d = (state_q == ST_RUN) && (mode_q == M_STEP) && !step_mode_s;

        if (step_entry_s) begin
            remaining_d = step_count;
        end else if (start_entry_s || left_step_d) begin
            remaining_d = '0;
        end else if (step_mode_s && raw_edge_s) begin
            remaining_d = remaining_q - STEP_W'(1);
        end else begin
            remaining_d = remaining_q;
        end

        state_d       = state_q;
        halt_cause_d  = halt_cause_q;
        cycle_count_d = cycle_count_q;
        bp_armed_d    = bp_armed_q;
        case (state_q)
            ST_RUN: begin
                if (halt_s) begin
                    state_d      = ST_HALT;
                    halt_cause_d = cause_s;
                end else if (cpu_tick_d) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                    bp_armed_d    = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_IDLE, ST_HALT: begin
                if (start_entry_s || step_entry_s) begin
                    state_d       = ST_RUN;
                    halt_cause_d  = C_NONE;
                    cycle_count_d = '0;
                    bp_armed_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; start_q/mode_q track inputs even in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            start_q       <= start_tgl;
            mode_q        <= mode;
            div_q         <= '0;
            slow_clk_q    <= 1'b0;
            remaining_q   <= '0;
            bp_armed_q    <= 1'b0;
            left_step_q   <= 1'b0;
            cpu_tick_q    <= 1'b0;
            halt_cause_q  <= C_NONE;
            cycle_count_q <= '0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_tgl;
            mode_q        <= mode;
            div_q         <= div_d;
            slow_clk_q    <= slow_clk_d;
            remaining_q   <= remaining_d;
            bp_armed_q    <= bp_armed_d;
            left_step_q   <= left_step_d;
            cpu_tick_q    <= cpu_tick_d;
            halt_cause_q  <= halt_cause_d;
            cycle_count_q <= cycle_count_d;
            running_q     <= (state_d == ST_RUN);
        end
    end

    assign cpu_tick    = cpu_tick_q;
    assign slow_clk    = slow_clk_q;
    assign running     = running_q;
    assign halt_cause  = halt_cause_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed stimulus, expected ticks queued and matched by a monitor.
module tb_cpu_run_ctrl;

    localparam int PC_W   = 16;
    localparam int STEP_W = 16;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        mode;
    logic              start_tgl;
    logic              done;
    logic              step_req;
    logic [STEP_W-1:0] step_count;
    logic              bp_en;
    logic [PC_W-1:0]   bp_addr;
    logic [PC_W-1:0]   pc;
    logic              cpu_tick;
    logic              slow_clk;
    logic              running;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  cycle_count;

    typedef struct {
        int cnt;
        int gap;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    int              checks = 0;
    int              passes = 0;
    int              n_ticks = 0;
    int              last_tick = 0;
    int              tick_base = 0;
    int              cyc = 0;
    int              base;
    logic            pc_follow = 1'b0;
    logic [PC_W-1:0] pc_hold = '0;

    assign pc = pc_follow ? PC_W'(n_ticks - tick_base) : pc_hold;

    cpu_run_ctrl #(
        .CLK_DIV(4),
        .PC_W(PC_W),
        .STEP_W(STEP_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .start_tgl(start_tgl),
        .done(done),
        .step_req(step_req),
        .step_count(step_count),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc(pc),
        .cpu_tick(cpu_tick),
        .slow_clk(slow_clk),
        .running(running),
        .halt_cause(halt_cause),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int cnt, input int gap);
        exp_t x;
        x.cnt = cnt;
        x.gap = gap;
        sb.push_back(x);
    endtask

    task automatic wait_ticks(input string name, input int target, input int budget);
        int k = 0;
        while ((n_ticks < target) && (k < budget)) begin
            step(1);
            k++;
        end
        chk(name, n_ticks, target);
    endtask

    task automatic drain(input string name);
        chk(name, sb.size(), 0);
    endtask

    // Tick monitor: every cpu_tick pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (cpu_tick) begin
            n_ticks++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_tick: cpu_tick=1 with cycle_count=%0d, expected no tick (cycle %0d)",
                         cycle_count, cyc);
            end else begin
                e = sb.pop_front();
                chk("tick_cycle_count", cycle_count, e.cnt);
                if (e.gap >= 0) chk("tick_spacing", cyc - last_tick, e.gap);
            end
            last_tick = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mode = 3'd0; start_tgl = 1'b0; done = 1'b0;
        step_req = 1'b0; step_count = '0; bp_en = 1'b0; bp_addr = '0;
        step(3);
        chk("rst_running", running, 0);
        chk("rst_halt_cause", halt_cause, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_cpu_tick", cpu_tick, 0);
        chk("rst_slow_clk", slow_clk, 0);
        reset = 1'b0;
        step(1);
        chk("idle_running", running, 0);

        // FAST: ticks every 2 cycles, done halts with cause 1
        mode = 3'd1;
        step(2);
        base = n_ticks;
        push(1, -1); push(2, 2); push(3, 2); push(4, 2); push(5, 2);
        start_tgl = 1'b1;
        step(1);
        chk("fast_running", running, 1);
        wait_ticks("fast_ticks", base + 5, 30);
        done = 1'b1;
        step(1);
        chk("fast_halt_running", running, 0);
        chk("fast_halt_cause", halt_cause, 1);
        chk("fast_halt_count", cycle_count, 5);
        step(6);
        drain("fast_drain");
        chk("fast_no_more_ticks", n_ticks, base + 5);
        done = 1'b0;

        // SLOW with CLK_DIV=4: ticks 8 cycles apart, OFF stops them
        mode = 3'd2;
        step(1);
        base = n_ticks;
        push(1, -1); push(2, 8); push(3, 8);
        start_tgl = 1'b0;
        step(1);
        chk("slow_running", running, 1);
        wait_ticks("slow_ticks", base + 3, 60);
        step(3);
        mode = 3'd0;
        step(20);
        drain("slow_drain");
        chk("off_slow_clk", slow_clk, 0);
        chk("off_no_ticks", n_ticks, base + 3);
        chk("off_still_running", running, 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk("off_halt_cause", halt_cause, 1);

        // STEP burst of 3 then cause 3; zero-length request ignored
        mode = 3'd5;
        step(1);
        base = n_ticks;
        push(1, -1); push(2, 1); push(3, 1);
        step_count = 16'd3;
        step_req = 1'b1;
        step(1);
        step_req = 1'b0;
        chk("step_running", running, 1);
        step(4);
        chk("step_halt_running", running, 0);
        chk("step_halt_cause", halt_cause, 3);
        chk("step_count_after", cycle_count, 3);
        chk("step_tick_total", n_ticks, base + 3);
        drain("step_drain");
        step_count = 16'd0;
        step_req = 1'b1;
        step(1);
        step_req = 1'b0;
        step(3);
        chk("step0_running", running, 0);
        chk("step0_halt_cause", halt_cause, 3);
        chk("step0_count", cycle_count, 3);

        // Breakpoint at pc=4, then resume with pc held at 4
        mode = 3'd1;
        bp_en = 1'b1;
        bp_addr = 16'h0004;
        step(1);
        tick_base = n_ticks;
        pc_follow = 1'b1;
        push(1, -1); push(2, 2); push(3, 2); push(4, 2);
        start_tgl = 1'b1;
        wait_ticks("bp_ticks", tick_base + 4, 30);
        chk("bp_halt_running", running, 0);
        chk("bp_halt_cause", halt_cause, 2);
        chk("bp_halt_count", cycle_count, 4);
        drain("bp_drain");
        pc_hold = 16'h0004;
        pc_follow = 1'b0;
        push(1, -1);
        start_tgl = 1'b0;
        step(1);
        chk("bp_resume_running", running, 1);
        step(5);
        chk("bp_rehalt_running", running, 0);
        chk("bp_rehalt_cause", halt_cause, 2);
        chk("bp_resume_count", cycle_count, 1);
        drain("bp_resume_drain");
        bp_en = 1'b0;

        // MANUAL: each 3->4 transition gives exactly one tick
        mode = 3'd3;
        step(1);
        start_tgl = 1'b1;
        step(1);
        chk("man_running", running, 1);
        base = n_ticks;
        push(1, -1);
        mode = 3'd4;
        step(3);
        mode = 3'd3;
        step(2);
        push(2, -1);
        mode = 3'd4;
        step(6);
        chk("man_ticks", n_ticks, base + 2);
        drain("man_drain");
        chk("man_slow_clk_hi", slow_clk, 1);
        chk("man_count", cycle_count, 2);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk("man_halt_cause", halt_cause, 1);

        // Reset during a 10-step burst after 4 ticks; start level held through reset
        mode = 3'd5;
        step(1);
        base = n_ticks;
        push(1, -1); push(2, 1); push(3, 1); push(4, 1);
        step_count = 16'd10;
        step_req = 1'b1;
        start_tgl = 1'b0;
        step(1);
        step_req = 1'b0;
        step(4);
        reset = 1'b1;
        start_tgl = 1'b1;
        mode = 3'd1;
        step(1);
        chk("mrst_cpu_tick", cpu_tick, 0);
        chk("mrst_running", running, 0);
        chk("mrst_halt_cause", halt_cause, 0);
        chk("mrst_cycle_count", cycle_count, 0);
        chk("mrst_slow_clk", slow_clk, 0);
        step(2);
        reset = 1'b0;
        step(6);
        chk("mrst_no_start", running, 0);
        chk("mrst_count_idle", cycle_count, 0);
        chk("mrst_tick_total", n_ticks, base + 4);
        drain("mrst_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
